// File: rtl/fp_add_align_pkg.sv
// Shared single-precision field definitions for the FP add alignment slice.
package fp_add_align_pkg;

    localparam int unsigned FRAC_W  = 26;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned MAN_W   = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam int unsigned BIAS    = 127;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp_unpacked_t;

    function automatic logic is_special(input logic [EXP_W-1:0] exp);
        return exp == EXP_MAX;
    endfunction

endpackage

// File: rtl/fp_add_align_unpack.sv
// Splits an IEEE-754 single into sign, effective exponent and 26-bit fraction
// ({hidden, mantissa, 2'b00}); denormals use effective exponent 1.
module fp_unpack
    import fp_add_align_pkg::*;
(
    input  logic [31:0]  i_word,
    output fp_unpacked_t o_op
);

    logic [EXP_W-1:0] w_exp_raw;
    logic             w_hidden;

    assign w_exp_raw = i_word[30:23];
    assign w_hidden  = (w_exp_raw != '0);

    always_comb begin
        o_op.sign = i_word[31];
        o_op.exp  = w_hidden ? w_exp_raw : 8'd1;
        o_op.frac = {w_hidden, i_word[MAN_W-1:0], 2'b00};
    end

endmodule

// File: rtl/fp_add_align.sv
// Two-stage operand alignment front end for an FP adder (valid/ready pipeline).
// Optional macro FP_ALIGN_STICKY_EN enables the sticky-bit computation.
module fp_add_align
    import fp_add_align_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    input  logic              sub_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_large,
    output logic [FRAC_W-1:0] frac_large,
    output logic [FRAC_W-1:0] frac_small,
    output logic [EXP_W-1:0]  shift_amount,
    output logic              swap,
    output logic              sign_large,
    output logic              sign_small,
    output logic              eff_sub,
    output logic              special,
    output logic              sticky
);

    fp_unpacked_t w_a, w_b;
    fp_unpacked_t r_s1_a, r_s1_b;
    logic [8:0]   r_s1_diff;
    logic         r_s1_sub;
    logic         r_s1_valid;

    logic              r_s2_valid;
    logic [EXP_W-1:0]  r_exp_large;
    logic [FRAC_W-1:0] r_frac_large, r_frac_small;
    logic [EXP_W-1:0]  r_shift;
    logic              r_swap, r_sign_large, r_sign_small, r_eff_sub, r_special;

    logic w_s1_load, w_s2_load;
    logic w_swap, w_special;
    logic [EXP_W-1:0] w_shift;
    fp_unpacked_t w_large, w_small;

    fp_unpack u_unpack_a (.i_word(op_a), .o_op(w_a));
    fp_unpack u_unpack_b (.i_word(op_b), .o_op(w_b));

    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_diff  <= '0;
            r_s1_sub   <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a    <= w_a;
                r_s1_b    <= w_b;
                r_s1_diff <= {1'b0, w_a.exp} - {1'b0, w_b.exp};
                r_s1_sub  <= sub_op;
            end
        end
    end

    // |diff| never exceeds 254, so the 8-bit two's-complement negate is exact.
    always_comb begin
        w_swap    = r_s1_diff[8];
        w_large   = w_swap ? r_s1_b : r_s1_a;
        w_small   = w_swap ? r_s1_a : r_s1_b;
        w_shift   = w_swap ? (8'd0 - r_s1_diff[7:0]) : r_s1_diff[7:0];
        w_special = is_special(r_s1_a.exp) || is_special(r_s1_b.exp);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s2_valid   <= 1'b0;
            r_exp_large  <= '0;
            r_frac_large <= '0;
            r_frac_small <= '0;
            r_shift      <= '0;
            r_swap       <= 1'b0;
            r_sign_large <= 1'b0;
            r_sign_small <= 1'b0;
            r_eff_sub    <= 1'b0;
            r_special    <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_exp_large  <= w_large.exp;
                r_frac_large <= w_large.frac;
                r_frac_small <= w_small.frac;
                r_shift      <= w_shift;
                r_swap       <= w_swap;
                r_sign_large <= w_large.sign;
                r_sign_small <= w_small.sign;
                r_eff_sub    <= r_s1_sub ^ r_s1_a.sign ^ r_s1_b.sign;
                r_special    <= w_special;
            end
        end
    end

`ifdef FP_ALIGN_STICKY_EN
    logic w_sticky;
    logic r_sticky;

    always_comb begin
        w_sticky = 1'b0;
        for (int unsigned i = 0; i < FRAC_W; i++) begin
            if (i < 32'(w_shift)) w_sticky = w_sticky | w_small.frac[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sticky <= 1'b0;
        end else if (w_s2_load && r_s1_valid) begin
            r_sticky <= w_sticky;
        end
    end

    assign sticky = r_sticky;
`else
    assign sticky = 1'b0;
`endif

    assign out_valid    = r_s2_valid;
    assign exp_large    = r_exp_large;
    assign frac_large   = r_frac_large;
    assign frac_small   = r_frac_small;
    assign shift_amount = r_shift;
    assign swap         = r_swap;
    assign sign_large   = r_sign_large;
    assign sign_small   = r_sign_small;
    assign eff_sub      = r_eff_sub;
    assign special      = r_special;

endmodule

// File: tb/tb_fp_add_align.sv
// Scoreboard bench for fp_add_align: driver queues hand-computed results,
// a negedge monitor pops and compares on each output transfer.
module tb_fp_add_align;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, sub_op;
    logic [31:0] op_a, op_b;
    logic        out_valid, out_ready;
    logic [7:0]  exp_large, shift_amount;
    logic [25:0] frac_large, frac_small;
    logic        swap, sign_large, sign_small, eff_sub, special, sticky;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    typedef struct packed {
        logic        swap;
        logic        sign_large;
        logic        sign_small;
        logic        eff_sub;
        logic        special;
        logic        sticky;
        logic [7:0]  exp_large;
        logic [7:0]  shift;
        logic [25:0] frac_large;
        logic [25:0] frac_small;
    } res_t;

    res_t exp_q[$];
    res_t held;
    bit   held_v = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fp_add_align dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub_op(sub_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_large(exp_large), .frac_large(frac_large), .frac_small(frac_small),
        .shift_amount(shift_amount), .swap(swap),
        .sign_large(sign_large), .sign_small(sign_small),
        .eff_sub(eff_sub), .special(special), .sticky(sticky)
    );

    always #5 CLK = ~CLK;

    function automatic res_t mk(input logic sw, input logic sl, input logic ss,
                                input logic es, input logic sp, input logic st,
                                input logic [7:0] el, input logic [7:0] sh,
                                input logic [25:0] fl, input logic [25:0] fs);
        res_t r;
        r.swap = sw; r.sign_large = sl; r.sign_small = ss; r.eff_sub = es;
        r.special = sp; r.sticky = st; r.exp_large = el; r.shift = sh;
        r.frac_large = fl; r.frac_small = fs;
        return r;
    endfunction

    function automatic res_t dut_res();
        return {swap, sign_large, sign_small, eff_sub, special, sticky,
                exp_large, shift_amount, frac_large, frac_small};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: output transfers happen at the next posedge, so negedge values are what moves.
    always @(negedge CLK) begin
        res_t e;
        if (RST) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                n_tests++;
                if (dut_res() !== held) begin
                    n_fail++;
                    $display("FAIL hold_stable: got %h expected %h", dut_res(), held);
                end
            end
            held_v = out_valid && !out_ready;
            held   = dut_res();
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got %h expected none", dut_res());
                end else begin
                    e = exp_q.pop_front();
                    if (dut_res() !== e) begin
                        n_fail++;
                        $display("FAIL result: got %h expected %h", dut_res(), e);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t e);
        int unsigned cyc = 0;
        op_a = a; op_b = b; sub_op = s; in_valid = 1'b1;
        @(negedge CLK);
        while (!in_ready && cyc < 50) begin
            cyc++;
            @(negedge CLK);
        end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge CLK);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        int unsigned cyc = 0;
        @(negedge CLK);
        while ((exp_q.size() != 0 || out_valid) && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
        n_tests++;
        if (exp_q.size() != 0 || out_valid) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    res_t v_add, v_eq, v_far, v_inf, v_sub, v_den, v_stk, v_neg, v_nan;

    initial begin
        v_add = mk(1, 0, 0, 0, 0, 0,   8'h80, 8'd1,   26'h2000000, 26'h2000000);
        v_eq  = mk(0, 0, 0, 0, 0, 0,   8'h80, 8'd0,   26'h3000000, 26'h3000000);
        v_far = mk(0, 0, 0, 0, 0, STK, 8'h7F, 8'd30,  26'h2000000, 26'h2000004);
        v_inf = mk(0, 0, 0, 0, 1, STK, 8'hFF, 8'd128, 26'h2000000, 26'h2000000);
        v_sub = mk(0, 1, 0, 0, 0, 0,   8'h80, 8'd1,   26'h2000000, 26'h2000000);
        v_den = mk(0, 0, 0, 0, 0, 0,   8'h01, 8'd0,   26'h000000C, 26'h2000000);
        v_stk = mk(0, 0, 0, 1, 0, STK, 8'h82, 8'd3,   26'h2000000, 26'h2000004);
        v_neg = mk(1, 1, 0, 1, 0, 0,   8'h82, 8'd3,   26'h2000000, 26'h2000000);
        v_nan = mk(1, 0, 0, 0, 1, STK, 8'hFF, 8'd128, 26'h3000000, 26'h2000000);

        RST = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub_op = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_out_valid",  32'(out_valid), 32'd0);
        chk("rst_exp_large",  32'(exp_large), 32'd0);
        chk("rst_frac_large", 32'(frac_large), 32'd0);
        chk("rst_shift",      32'(shift_amount), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge CLK);
        #1;

        send(32'h3F800000, 32'h40000000, 1'b0, v_add);
        send(32'h40400000, 32'h40400000, 1'b0, v_eq);
        send(32'h3F800000, 32'h30800001, 1'b0, v_far);
        send(32'h7F800000, 32'h3F800000, 1'b0, v_inf);
        send(32'hC0000000, 32'h3F800000, 1'b1, v_sub);
        send(32'h00000003, 32'h00800000, 1'b0, v_den);
        send(32'h41000000, 32'h3F800001, 1'b1, v_stk);
        send(32'h3F800000, 32'hC1000000, 1'b0, v_neg);
        send(32'h3F800000, 32'h7FC00000, 1'b0, v_nan);
        wait_empty();

        fork
            begin
                send(32'h3F800000, 32'h40000000, 1'b0, v_add);
                send(32'h40400000, 32'h40400000, 1'b0, v_eq);
                send(32'hC0000000, 32'h3F800000, 1'b1, v_sub);
                send(32'h00000003, 32'h00800000, 1'b0, v_den);
            end
            begin
                out_ready = 1'b0;
                repeat (2) @(posedge CLK);
                @(negedge CLK);
                chk("stall_in_ready", 32'(in_ready), 32'd0);
                repeat (2) @(posedge CLK);
                #1 out_ready = 1'b1;
            end
        join
        wait_empty();

        send(32'h3F800000, 32'h40000000, 1'b0, v_add);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("post_rst_out_valid", 32'(out_valid), 32'd0);
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        send(32'h40400000, 32'h40400000, 1'b0, v_eq);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_add_align.md
FP_ADD_ALIGN -- requirements
Module: fp_add_align

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 in_valid  in  1  operand pair present.
REQ-004 in_ready  out  1  stage 1 can accept; transfer when in_valid & in_ready.
REQ-005 op_a, op_b  in  32 each  IEEE-754 single-precision operands.
REQ-006 sub_op  in  1  1 = A-B, 0 = A+B; carried through unchanged.
REQ-007 out_valid  out  1  aligned result present.
REQ-008 out_ready  in  1  downstream (right shifter/adder stage) accepts; transfer when out_valid & out_ready.
REQ-009 exp_large  out  8  larger biased exponent.
REQ-010 frac_large, frac_small  out  26 each  {hidden, mantissa[22:0], 2'b00}; frac_small unshifted, feeds right shifter fraction input.
REQ-011 shift_amount  out  8  exponent difference, feeds right shifter shift input.
REQ-012 swap  out  1  1 when B is the larger operand; sign_large, sign_small out 1 each; eff_sub out 1 = sub_op ^ sign_a ^ sign_b.
REQ-013 special  out  1  either operand has exponent 255 (Inf/NaN).
REQ-014 sticky  out  1  OR of frac_small bits shifted out by shift_amount (see Configuration).

Function
REQ-015 Two-stage pipeline; accepted pair appears at outputs exactly 2 cycles later when never stalled.
REQ-016 Stage 1 registers unpacked fields: hidden = (exp != 0); effective exponent = 1 when exp == 0 (denormal); 9-bit diff = exp_a_eff - exp_b_eff.
REQ-017 Stage 2 registers: swap = diff negative; larger operand to *_large, other to *_small; shift_amount = |diff| (0..254, no clamping).
REQ-018 Equal exponents: swap = 0, shift_amount = 0, A is large.
REQ-019 Each stage holds data while its successor stalls; a stage loads when empty or its contents move on the same cycle.
REQ-020 in_ready = !s1_valid | !s2_valid | out_ready (full-throughput, no bubble); 2 accepted items plus out_ready low = in_ready low.
REQ-021 Output data stable while out_valid & !out_ready.
REQ-022 Simultaneous accept and drain in one cycle: both occur, no loss, no duplication.
REQ-023 special computed combinationally from stage-1 exponents, registered into stage 2.

Reset
REQ-024 RST high at a clock edge: s1_valid, s2_valid, out_valid = 0; all data outputs = 0; in_ready = 1 the cycle after release.
REQ-025 RST mid-operation discards in-flight items; none emerge after reset.

Configuration
REQ-026 Macro FP_ALIGN_STICKY_EN defined: sticky = OR of frac_small[shift_amount-1:0], and = OR of all frac_small when shift_amount >= 26; computed in stage 2, same latency.
REQ-027 Macro undefined: sticky tied 0; no sticky logic synthesized.

Structure
REQ-028 Shared FP package holds: FRAC_W = 26, EXP_W = 8, EXP_MAX = 255, bias 127, and the unpacked-operand struct {sign, exp, frac}.
REQ-029 One sub-module fp_unpack (32-bit word -> sign, effective exponent, 26-bit fraction), instanced twice in stage 1.

Verification
REQ-030 op_a=0x3F800000, op_b=0x40000000, sub_op=0 -> 2 cycles later: swap=1, exp_large=0x80, shift_amount=1, frac_large=frac_small=0x2000000, eff_sub=0.
REQ-031 op_a=op_b=0x40400000 -> swap=0, shift_amount=0, frac_large=frac_small=0x3000000, sticky=0.
REQ-032 op_a=0x3F800000, op_b=0x30800001 (exp 97) -> swap=0, shift_amount=30, sticky=1 with FP_ALIGN_STICKY_EN, 0 without.
REQ-033 Back-to-back 4 pairs, out_ready low cycles 2-5 -> in_ready low once 2 held; all 4 emerge in order, unmodified, no duplicates.
REQ-034 op_a=0x7F800000, op_b=0x3F800000 -> special=1, exp_large=0xFF, shift_amount=128.
REQ-035 RST asserted 1 cycle after accepting a pair -> out_valid stays 0 for the following 4 cycles; next accepted pair emerges correctly.
